ama_riscv_flow_ctrl: RTL and testbench
======================================

AMA_RISCV_FLOW_CTRL -- requirements
Module: ama_riscv_flow_ctrl

Interface
REQ-001 Parameter FLOW_LAT, default 1, meaning: cycles from flow instruction in DEC to its resolution; legal 1..4.
REQ-002 Parameter PREDICT_NT, default 0, meaning: 0 = stall on every branch/jump, 1 = static not-taken, fetch continues and a flush is issued on redirect.
REQ-003 Parameter RST_SEQ_LEN, default 3, meaning: number of pipeline stages cleared by the post-reset sequence; legal 1..8.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 flow_inst_dec  input  1  branch or jump present in DEC this cycle.
REQ-007 res_valid  input  1  resolution result valid this cycle.
REQ-008 res_taken  input  1  resolved flow change (branch taken or jump); qualified by res_valid.
REQ-009 imem_req_ready  input  1  imem accepts a request.
REQ-010 imem_rsp_valid  input  1  imem response (instruction) available.
REQ-011 imem_req_valid  output  1  fetch request to imem.
REQ-012 imem_rsp_ready  output  1  decoder accepts the imem response.
REQ-013 pc_we  output  1  PC register write enable.
REQ-014 pc_redirect  output  1  1 = PC loads resolved target, 0 = PC+4; meaningful only with pc_we.
REQ-015 bubble_dec  output  1  inject NOP into DEC.
REQ-016 flush_young  output  1  clear all stages younger than the resolution stage (PREDICT_NT=1 only; tied 0 otherwise).
REQ-017 clear  output  RST_SEQ_LEN  post-reset per-stage clear; bit 0 = DEC, higher bits = later stages.
REQ-018 stall_cnt  output  32  count of cycles with bubble_dec=1.

Function
REQ-019 The FSM SHALL have states RST, STEADY, STALL_FLOW, STALL_IMEM; RST SHALL be entered on reset and left after exactly one cycle for STEADY.
REQ-020 In RST: imem_req_valid=1, imem_rsp_ready=1, pc_we=1, pc_redirect=0, bubble_dec=1.
REQ-021 A shift register SHALL reset to all ones and shift left, filling with 0, each cycle; clear SHALL equal it, so clear[i] deasserts i+1 cycles after reset release.
REQ-022 STEADY, no event: imem_req_valid=1, imem_rsp_ready=1, pc_we=1, pc_redirect=0, bubble_dec=0.
REQ-023 STEADY with flow_inst_dec and PREDICT_NT=0: pc_we=0, imem_req_valid=0, imem_rsp_ready=0; load flow counter with FLOW_LAT-1; go to STALL_FLOW.
REQ-024 STEADY with !imem_rsp_valid (and no stalling flow instruction): pc_we=0, imem_req_valid=0, bubble_dec=1; go to STALL_IMEM.
REQ-025 STALL_FLOW: bubble_dec=1; while counter != 0 hold pc_we=0, imem_req_valid=0, decrement the counter.
REQ-026 STALL_FLOW, counter == 0: pc_we=1, pc_redirect=res_valid&&res_taken (res_valid=0 means not taken), imem_req_valid=1, imem_rsp_ready=1; next STEADY.
REQ-027 STALL_IMEM: pc_we=0, imem_req_valid=0, imem_rsp_ready=1, bubble_dec=1 until imem_rsp_valid.
REQ-028 STALL_IMEM with imem_rsp_valid: if flow_inst_dec and PREDICT_NT=0, apply REQ-023 outputs with bubble_dec=0 and go to STALL_FLOW; otherwise pc_we=1, imem_req_valid=1, bubble_dec=0 and go to STEADY only if imem_req_ready, else remain in STALL_IMEM.
REQ-029 PREDICT_NT=1: flow_inst_dec SHALL NOT stall; res_valid&&res_taken in STEADY or STALL_IMEM SHALL force pc_we=1, pc_redirect=1, flush_young=1, bubble_dec=1 in that cycle.
REQ-030 Redirect has priority over an imem stall in the same cycle.
REQ-031 Redirect in STALL_IMEM SHALL set a drop flag; the next imem_rsp_valid SHALL be accepted (imem_rsp_ready=1) with bubble_dec=1, then clear the flag; the FSM stays in STALL_IMEM until a non-dropped response arrives.
REQ-032 stall_cnt SHALL increment on every cycle with bubble_dec=1 and wrap from 0xFFFFFFFF to 0.
REQ-033 pc_redirect SHALL be 0 whenever pc_we=0.

Reset
REQ-034 On rst: state=RST, flow counter=0, drop flag=0, stall_cnt=0, clear=all ones, flush_young=0.
REQ-035 rst asserted mid-stall SHALL abandon the stall immediately, with no pending redirect or drop surviving.

Verification
REQ-036 Reset release, imem always valid -> clear = 3'b111, 3'b110, 3'b100, 3'b000 on successive cycles; pc_we=1 from the RST cycle on.
REQ-037 PREDICT_NT=0, FLOW_LAT=2, branch in DEC, res_taken=1 -> pc_we low for 2 cycles, then pc_we=1 with pc_redirect=1; stall_cnt=2.
REQ-038 imem_rsp_valid low 3 cycles in STEADY -> bubble_dec=1 for 3 cycles, pc_we=0, then resume STEADY; stall_cnt += 3.
REQ-039 PREDICT_NT=1, res_taken pulse during STALL_IMEM -> pc_redirect=1, flush_young=1 for that cycle; the next response is dropped with bubble_dec=1.
REQ-040 rst asserted in the middle of STALL_FLOW -> outputs match REQ-020 and REQ-034 in the next cycle.
REQ-041 stall_cnt preloaded near 0xFFFFFFFF via force, then 2 bubbles -> value wraps to 0x00000000.

Source files
------------

// File: rtl/ama_riscv_flow_ctrl_if.sv
// Instruction-memory request/response handshake between the
// fetch flow controller (master) and the imem (slave).
interface ama_riscv_flow_ctrl_if;
    logic imem_req_valid;
    logic imem_req_ready;
    logic imem_rsp_valid;
    logic imem_rsp_ready;

    modport master (
        output imem_req_valid,
        output imem_rsp_ready,
        input  imem_req_ready,
        input  imem_rsp_valid
    );

    modport slave (
        input  imem_req_valid,
        input  imem_rsp_ready,
        output imem_req_ready,
        output imem_rsp_valid
    );
endinterface

// File: rtl/ama_riscv_flow_ctrl.sv
// Front-end flow control: PC write, fetch handshake, DEC bubbles,
// post-reset stage clears and branch/jump stall or flush handling.
module ama_riscv_flow_ctrl #(
    parameter int FLOW_LAT    = 1,
    parameter int PREDICT_NT  = 0,
    parameter int RST_SEQ_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    ama_riscv_flow_ctrl_if.master  imem,
    input  logic                   flow_inst_dec,
    input  logic                   res_valid,
    input  logic                   res_taken,
    output logic                   pc_we,
    output logic                   pc_redirect,
    output logic                   bubble_dec,
    output logic                   flush_young,
    output logic [RST_SEQ_LEN-1:0] clear,
    output logic [31:0]            stall_cnt
);
    typedef enum logic [1:0] {
        RST, STEADY, STALL_FLOW, STALL_IMEM
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(FLOW_LAT - 1);

    state_t state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic drop, drop_nxt;
    logic [RST_SEQ_LEN-1:0] clr_sr;
    logic req_valid, rsp_ready;
    logic redir, flow_stall, taken;

    assign taken      = res_valid && res_taken;
    assign redir      = (PREDICT_NT != 0) && taken;
    assign flow_stall = (PREDICT_NT == 0) && flow_inst_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST;
            cnt   <= 2'd0;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            drop  <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        drop_nxt  = drop;
        unique case (state)
            RST: state_nxt = STEADY;
            STEADY: begin
                if (redir) begin
                    state_nxt = STEADY;
                end else if (flow_stall) begin
                    cnt_nxt   = CNT_INIT;
                    state_nxt = STALL_FLOW;
                end else if (!imem.imem_rsp_valid) begin
                    state_nxt = STALL_IMEM;
                end
            end
            STALL_FLOW: begin
                if (cnt != 2'd0) cnt_nxt = cnt - 2'd1;
                else             state_nxt = STEADY;
            end
            STALL_IMEM: begin
                if (redir) begin
                    drop_nxt = 1'b1;
                end else if (imem.imem_rsp_valid) begin
                    if (drop) begin
                        drop_nxt = 1'b0;
                    end else if (flow_stall) begin
                        cnt_nxt   = CNT_INIT;
                        state_nxt = STALL_FLOW;
                    end else if (imem.imem_req_ready) begin
                        state_nxt = STEADY;
                    end
                end
            end
            default: state_nxt = RST;
        endcase
    end

    // redirect wins over both flow and imem stalls
    always_comb begin
        req_valid   = 1'b1;
        rsp_ready   = 1'b1;
        pc_we       = 1'b1;
        pc_redirect = 1'b0;
        bubble_dec  = 1'b0;
        flush_young = 1'b0;
        unique case (state)
            RST: bubble_dec = 1'b1;
            STEADY: begin
                if (redir) begin
                    pc_redirect = 1'b1;
                    flush_young = 1'b1;
                    bubble_dec  = 1'b1;
                end else if (flow_stall) begin
                    pc_we     = 1'b0;
                    req_valid = 1'b0;
                    rsp_ready = 1'b0;
                end else if (!imem.imem_rsp_valid) begin
                    pc_we      = 1'b0;
                    req_valid  = 1'b0;
                    bubble_dec = 1'b1;
                end
            end
            STALL_FLOW: begin
                bubble_dec = 1'b1;
                if (cnt != 2'd0) begin
                    pc_we     = 1'b0;
                    req_valid = 1'b0;
                    rsp_ready = 1'b0;
                end else begin
                    pc_redirect = taken;
                end
            end
            STALL_IMEM: begin
                if (redir) begin
                    pc_redirect = 1'b1;
                    flush_young = 1'b1;
                    bubble_dec  = 1'b1;
                end else if (!imem.imem_rsp_valid || drop) begin
                    pc_we      = 1'b0;
                    req_valid  = 1'b0;
                    bubble_dec = 1'b1;
                end else if (flow_stall) begin
                    pc_we     = 1'b0;
                    req_valid = 1'b0;
                    rsp_ready = 1'b0;
                end
            end
            default: begin
                pc_we      = 1'b0;
                req_valid  = 1'b0;
                bubble_dec = 1'b1;
            end
        endcase
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_rsp_ready = rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) clr_sr <= '1;
        else     clr_sr <= clr_sr << 1;
    end

    assign clear = clr_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             stall_cnt <= 32'd0;
        else if (bubble_dec) stall_cnt <= stall_cnt + 32'd1;
    end
endmodule

// File: tb/tb_ama_riscv_flow_ctrl.sv
// Directed bench for ama_riscv_flow_ctrl: a stall-mode instance
// and a predict-not-taken instance share one stimulus stream.
module tb_ama_riscv_flow_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic fi, rv, rt, rqr, rsv;
    logic we0, red0, bub0, fl0, we1, red1, bub1, fl1;
    logic [2:0] clr0, clr1;
    logic [31:0] cnt0, cnt1;

    ama_riscv_flow_ctrl_if if0();
    ama_riscv_flow_ctrl_if if1();
    assign if0.imem_req_ready = rqr;
    assign if0.imem_rsp_valid = rsv;
    assign if1.imem_req_ready = rqr;
    assign if1.imem_rsp_valid = rsv;

    ama_riscv_flow_ctrl #(.FLOW_LAT(2), .PREDICT_NT(0), .RST_SEQ_LEN(3)) u0 (
        .clk(clk), .rst(rst), .imem(if0),
        .flow_inst_dec(fi), .res_valid(rv), .res_taken(rt),
        .pc_we(we0), .pc_redirect(red0), .bubble_dec(bub0),
        .flush_young(fl0), .clear(clr0), .stall_cnt(cnt0)
    );

    ama_riscv_flow_ctrl #(.FLOW_LAT(1), .PREDICT_NT(1), .RST_SEQ_LEN(3)) u1 (
        .clk(clk), .rst(rst), .imem(if1),
        .flow_inst_dec(fi), .res_valid(rv), .res_taken(rt),
        .pc_we(we1), .pc_redirect(red1), .bubble_dec(bub1),
        .flush_young(fl1), .clear(clr1), .stall_cnt(cnt1)
    );

    // {clear[2:0], req_valid, rsp_ready, pc_we, pc_redirect, bubble, flush}
    localparam logic [5:0] RSTO = 6'b111010;
    localparam logic [5:0] STD  = 6'b111000;
    localparam logic [8:0] FULL = 9'h1FF;
    localparam logic [8:0] NORSP = 9'h1EF;
    localparam logic [8:0] NOREQ = 9'h1CF;

    typedef struct {
        string      tag;
        logic [8:0] e;
        logic [8:0] m;
        int         d;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] mcnt = 32'd0;

    function automatic logic [8:0] obs(input int d);
        if (d == 0)
            return {clr0, if0.imem_req_valid, if0.imem_rsp_ready,
                    we0, red0, bub0, fl0};
        return {clr1, if1.imem_req_valid, if1.imem_rsp_ready,
                we1, red1, bub1, fl1};
    endfunction

    task automatic cmp();
        exp_t x;
        logic [8:0] o;
        x = sb.pop_front();
        o = obs(x.d);
        checks++;
        assert ((o & x.m) === (x.e & x.m)) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b mask=%b",
                   x.tag, o, x.e, x.m);
        end
    endtask

    task automatic chk_cnt(input string tag, input int d);
        logic [31:0] c;
        c = (d == 0) ? cnt0 : cnt1;
        checks++;
        assert (c === mcnt) else begin
            errors++;
            $error("FAIL %s stall_cnt observed=%h expected=%h",
                   tag, c, mcnt);
        end
    endtask

    task automatic cyc(input string tag, input int d,
                       input logic fi_, input logic rv_, input logic rt_,
                       input logic rqr_, input logic rsv_,
                       input logic [8:0] e, input logic [8:0] m);
        fi = fi_; rv = rv_; rt = rt_; rqr = rqr_; rsv = rsv_;
        sb.push_back('{tag, e, m, d});
        @(negedge clk);
        cmp();
        @(posedge clk);
        if (e[1]) mcnt = mcnt + 32'd1;
        #1;
    endtask

    task automatic do_rst(input string tag);
        rst = 1'b1;
        fi = 0; rv = 0; rt = 0; rqr = 1; rsv = 1;
        #1;
        mcnt = 32'd0;
        sb.push_back('{{tag, "_u0"}, {3'b111, RSTO}, FULL, 0});
        cmp();
        sb.push_back('{{tag, "_u1"}, {3'b111, RSTO}, FULL, 1});
        cmp();
        chk_cnt({tag, "_cnt0"}, 0);
        chk_cnt({tag, "_cnt1"}, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        fi = 0; rv = 0; rt = 0; rqr = 1; rsv = 1;
        #2;
        do_rst("rst0");
        cyc("rst_cyc", 0, 0, 0, 0, 1, 1, {3'b111, RSTO}, FULL);
        cyc("clr110", 0, 0, 0, 0, 1, 1, {3'b110, STD}, FULL);
        cyc("clr100", 0, 0, 0, 0, 1, 1, {3'b100, STD}, FULL);
        cyc("clr000", 0, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        chk_cnt("cnt_rst", 0);

        cyc("br_dec", 0, 1, 0, 0, 1, 1, {3'b000, 6'b000000}, FULL);
        cyc("br_wait", 0, 0, 0, 0, 1, 1, {3'b000, 6'b000010}, FULL);
        cyc("br_res", 0, 0, 1, 1, 1, 1, {3'b000, 6'b111110}, FULL);
        cyc("br_std", 0, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        chk_cnt("cnt_br", 0);
        cyc("nt_dec", 0, 1, 0, 0, 1, 1, {3'b000, 6'b000000}, FULL);
        cyc("nt_wait", 0, 0, 0, 0, 1, 1, {3'b000, 6'b000010}, FULL);
        cyc("nt_res", 0, 0, 1, 0, 1, 1, {3'b000, 6'b111010}, FULL);
        cyc("nv_dec", 0, 1, 0, 0, 1, 1, {3'b000, 6'b000000}, FULL);
        cyc("nv_wait", 0, 0, 0, 0, 1, 1, {3'b000, 6'b000010}, FULL);
        cyc("nv_res", 0, 0, 0, 1, 1, 1, {3'b000, 6'b111010}, FULL);
        chk_cnt("cnt_nt", 0);

        cyc("im_miss", 0, 0, 0, 0, 1, 0, {3'b000, 6'b000010}, NORSP);
        cyc("im_wait1", 0, 0, 0, 0, 1, 0, {3'b000, 6'b010010}, FULL);
        cyc("im_wait2", 0, 0, 0, 0, 1, 0, {3'b000, 6'b010010}, FULL);
        cyc("im_resume", 0, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        cyc("im_std", 0, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        chk_cnt("cnt_im", 0);
        cyc("nr_miss", 0, 0, 0, 0, 1, 0, {3'b000, 6'b000010}, NORSP);
        cyc("nr_nordy", 0, 0, 0, 0, 0, 1, {3'b000, STD}, FULL);
        cyc("nr_rdy", 0, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        cyc("if_miss", 0, 0, 0, 0, 1, 0, {3'b000, 6'b000010}, NORSP);
        cyc("if_flow", 0, 1, 0, 0, 1, 1, {3'b000, 6'b000000}, FULL);
        cyc("if_wait", 0, 0, 0, 0, 1, 1, {3'b000, 6'b000010}, FULL);
        cyc("if_res", 0, 0, 1, 0, 1, 1, {3'b000, 6'b111010}, FULL);
        cyc("if_std", 0, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        chk_cnt("cnt_if", 0);

        force u0.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release u0.stall_cnt;
        mcnt = 32'hFFFF_FFFE;
        chk_cnt("cnt_pre", 0);
        cyc("wr_miss", 0, 0, 0, 0, 1, 0, {3'b000, 6'b000010}, NORSP);
        chk_cnt("cnt_ff", 0);
        cyc("wr_wait", 0, 0, 0, 0, 1, 0, {3'b000, 6'b010010}, FULL);
        chk_cnt("cnt_wrap", 0);
        cyc("wr_resume", 0, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);

        cyc("rf_dec", 0, 1, 0, 0, 1, 1, {3'b000, 6'b000000}, FULL);
        cyc("rf_wait", 0, 0, 0, 0, 1, 1, {3'b000, 6'b000010}, FULL);
        do_rst("rst_flow");
        cyc("rf_rst", 0, 0, 0, 0, 1, 1, {3'b111, RSTO}, FULL);
        cyc("rf_std", 0, 0, 0, 0, 1, 1, {3'b110, STD}, FULL);

        cyc("p_clr100", 1, 0, 0, 0, 1, 1, {3'b100, STD}, FULL);
        cyc("p_clr000", 1, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        cyc("p_flow", 1, 1, 0, 0, 1, 1, {3'b000, STD}, FULL);
        cyc("p_redir", 1, 0, 1, 1, 1, 1, {3'b000, 6'b001111}, NOREQ);
        cyc("p_after", 1, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        cyc("p_redir_miss", 1, 0, 1, 1, 1, 0, {3'b000, 6'b001111}, NOREQ);
        cyc("p_after2", 1, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        cyc("p_miss", 1, 0, 0, 0, 1, 0, {3'b000, 6'b000010}, NORSP);
        cyc("p_redir_im", 1, 0, 1, 1, 1, 0, {3'b000, 6'b001111}, NOREQ);
        cyc("p_wait", 1, 0, 0, 0, 1, 0, {3'b000, 6'b010010}, FULL);
        cyc("p_drop", 1, 0, 0, 0, 1, 1, {3'b000, 6'b010010}, FULL);
        cyc("p_resume", 1, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        cyc("p_std", 1, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        chk_cnt("cnt_p", 1);

        cyc("pd_miss", 1, 0, 0, 0, 1, 0, {3'b000, 6'b000010}, NORSP);
        cyc("pd_redir", 1, 0, 1, 1, 1, 0, {3'b000, 6'b001111}, NOREQ);
        do_rst("rst_drop");
        cyc("pd_rst", 1, 0, 0, 0, 1, 1, {3'b111, RSTO}, FULL);
        cyc("pd_std", 1, 0, 0, 0, 1, 1, {3'b110, STD}, FULL);
        cyc("pd_miss2", 1, 0, 0, 0, 1, 0, {3'b100, 6'b000010}, NORSP);
        cyc("pd_nodrop", 1, 0, 0, 0, 1, 1, {3'b000, STD}, FULL);
        chk_cnt("cnt_pd", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
